// File: rtl/booth_mult_unit.sv
// Sequential radix-2 Booth multiplier, WIDTH x WIDTH -> 2*WIDTH, signed or unsigned.
// One operation in flight; start/ready/done handshake with hi/lo held until the next result.

// One Booth iteration: conditional add/sub of M into A, then arithmetic shift of {A, Q, q_1}.
module booth_mult_step #(
  parameter int W1 = 33
) (
  input  logic [W1:0]   i_a,
  input  logic [W1-1:0] i_q,
  input  logic          i_q1,
  input  logic [W1-1:0] i_m,
  output logic [W1:0]   o_a,
  output logic [W1-1:0] o_q,
  output logic          o_q1
);
  logic [W1:0] w_m_ext;
  logic [W1:0] w_sum;

  assign w_m_ext = {i_m[W1-1], i_m};

  always_comb begin
    w_sum = i_a;
    unique case ({i_q[0], i_q1})
      2'b01:   w_sum = i_a + w_m_ext;
      2'b10:   w_sum = i_a - w_m_ext;
      default: w_sum = i_a;
    endcase
  end

  assign o_a  = {w_sum[W1], w_sum[W1:1]};
  assign o_q  = {w_sum[0], i_q[W1-1:1]};
  assign o_q1 = i_q[0];
endmodule

module booth_mult_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] op_a,
  input  logic [WIDTH-1:0] op_b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int W1 = WIDTH + 1;
  localparam int CW = $clog2(W1 + 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [W1-1:0]    r_m;
  logic [W1-1:0]    r_q;
  logic [W1:0]      r_a;
  logic             r_q1;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  logic [W1-1:0]    w_ext_a;
  logic [W1-1:0]    w_ext_b;
  logic [W1:0]      w_a_nxt;
  logic [W1-1:0]    w_q_nxt;
  logic             w_q1_nxt;
  logic             w_last;

  // Extra top bit makes unsigned all-ones operands representable as positive Booth inputs.
  assign w_ext_a = {is_signed & op_a[WIDTH-1], op_a};
  assign w_ext_b = {is_signed & op_b[WIDTH-1], op_b};
  assign w_last  = (r_cnt == CW'(1));

  booth_mult_step #(.W1(W1)) u_step (
    .i_a  (r_a),
    .i_q  (r_q),
    .i_q1 (r_q1),
    .i_m  (r_m),
    .o_a  (w_a_nxt),
    .o_q  (w_q_nxt),
    .o_q1 (w_q1_nxt)
  );

  always_ff @(posedge clk) begin
    if (!Reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!Reset) begin
      r_m   <= '0;
      r_q   <= '0;
      r_a   <= '0;
      r_q1  <= 1'b0;
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: if (start) begin
          r_m   <= w_ext_a;
          r_q   <= w_ext_b;
          r_a   <= '0;
          r_q1  <= 1'b0;
          r_cnt <= CW'(W1);
        end
        S_RUN: begin
          r_a   <= w_a_nxt;
          r_q   <= w_q_nxt;
          r_q1  <= w_q1_nxt;
          r_cnt <= r_cnt - CW'(1);
          // Product is the low 2*WIDTH bits of {A[W1-1:0], Q} after the final step.
          if (w_last) begin
            r_lo <= w_q_nxt[WIDTH-1:0];
            r_hi <= {w_a_nxt[WIDTH-2:0], w_q_nxt[WIDTH]};
          end
        end
        default: ;
      endcase
    end
  end

  assign ready = (r_state == S_IDLE);
  assign busy  = (r_state == S_RUN);
  assign done  = (r_state == S_DONE);
  assign hi    = r_hi;
  assign lo    = r_lo;
endmodule

// File: tb/tb_booth_mult_unit.sv
// Directed bench for booth_mult_unit: cycle-level protocol model plus literal product checks.
module tb_booth_mult_unit;
  localparam int W = 32;
  localparam int DONE_PH = W + 2;

  logic         clk = 1'b0;
  logic         Reset = 1'b0;
  logic         start = 1'b0;
  logic         is_signed = 1'b0;
  logic [W-1:0] op_a = '0;
  logic [W-1:0] op_b = '0;
  logic         ready, busy, done;
  logic [W-1:0] hi, lo;

  int checks = 0;
  int errors = 0;
  int done_cnt = 0;

  always #5 clk = ~clk;

  booth_mult_unit #(.WIDTH(W)) dut (
    .clk       (clk),
    .Reset     (Reset),
    .start     (start),
    .is_signed (is_signed),
    .op_a      (op_a),
    .op_b      (op_b),
    .ready     (ready),
    .busy      (busy),
    .done      (done),
    .hi        (hi),
    .lo        (lo)
  );

  function automatic logic [2*W-1:0] ref_mul(input logic s, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [2*W-1:0] xa, xb;
    xa = s ? {{W{a[W-1]}}, a} : {{W{1'b0}}, a};
    xb = s ? {{W{b[W-1]}}, b} : {{W{1'b0}}, b};
    return xa * xb;
  endfunction

  // Model: phase 0 idle, 1..W+1 running, W+2 done; result published on entering done.
  int             m_phase = 0;
  logic           m_valid = 1'b0;
  logic [2*W-1:0] m_prod = '0;
  logic [2*W-1:0] m_res = '0;

  always @(posedge clk) begin
    if (!Reset) begin
      m_valid <= 1'b1;
      m_phase <= 0;
      m_res   <= '0;
    end else if (m_phase == 0) begin
      if (start) begin
        m_phase <= 1;
        m_prod  <= ref_mul(is_signed, op_a, op_b);
      end
    end else if (m_phase < DONE_PH) begin
      m_phase <= m_phase + 1;
      if (m_phase == DONE_PH - 1) m_res <= m_prod;
    end else begin
      m_phase <= 0;
    end
  end

  task automatic chk(input string name, input logic [2*W-1:0] act, input logic [2*W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every stimulus step goes through tick, so the model compare runs on every cycle.
  task automatic tick();
    @(negedge clk);
    if (m_valid) begin
      chk("ready", 64'(ready), 64'(m_phase == 0));
      chk("busy",  64'(busy),  64'(m_phase >= 1 && m_phase < DONE_PH));
      chk("done",  64'(done),  64'(m_phase == DONE_PH));
      chk("hilo",  {hi, lo}, m_res);
    end
    if (done) done_cnt++;
  endtask

  task automatic wait_done(input int budget, output int n);
    n = -1;
    for (int i = 1; i <= budget; i++) begin
      tick();
      if (done) begin
        n = i;
        break;
      end
    end
    if (n < 0) chk("done_timeout", 64'(0), 64'(1));
  endtask

  task automatic run_op(input logic s, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [W-1:0] eh, input logic [W-1:0] el);
    int n;
    chk("model_pin", ref_mul(s, a, b), {eh, el});
    tick();
    start = 1'b1; is_signed = s; op_a = a; op_b = b;
    tick();
    start = 1'b0; op_a = $urandom; op_b = $urandom; is_signed = ~s;
    wait_done(60, n);
    chk("latency", 64'(n + 1), 64'(DONE_PH));
    chk("result", {hi, lo}, {eh, el});
  endtask

  initial begin
    int n, d0;
    // Reset state
    tick(); tick();
    Reset = 1'b1;
    tick();
    chk("rst_ready", 64'(ready), 64'(1));
    chk("rst_busy",  64'(busy),  64'(0));
    chk("rst_done",  64'(done),  64'(0));
    chk("rst_hilo",  {hi, lo},   64'(0));

    run_op(1'b1, 32'd3,        32'd4,        32'h0000_0000, 32'h0000_000C);
    tick();
    chk("ready_after_done", 64'(ready), 64'(1));
    run_op(1'b1, 32'hFFFF_FFFB, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFDD);
    run_op(1'b1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000);
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
    run_op(1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001);
    run_op(1'b0, 32'h8000_0000, 32'h0000_0002, 32'h0000_0001, 32'h0000_0000);

    // Start during RUN is ignored
    tick();
    d0 = done_cnt;
    start = 1'b1; is_signed = 1'b0; op_a = 32'd2; op_b = 32'd3;
    tick();
    start = 1'b0;
    repeat (5) tick();
    start = 1'b1; op_a = 32'd6; op_b = 32'd7;
    tick();
    start = 1'b0;
    wait_done(60, n);
    chk("ignored_start_result", {hi, lo}, 64'd6);
    repeat (40) tick();
    chk("one_done_pulse", 64'(done_cnt - d0), 64'(1));
    chk("hold_hilo", {hi, lo}, 64'd6);

    // Reset mid-RUN aborts without a done pulse
    start = 1'b1; is_signed = 1'b1; op_a = 32'd3; op_b = 32'd4;
    tick();
    start = 1'b0;
    repeat (9) tick();
    chk("busy_before_abort", 64'(busy), 64'(1));
    Reset = 1'b0;
    d0 = done_cnt;
    tick();
    chk("abort_ready", 64'(ready), 64'(1));
    chk("abort_busy",  64'(busy),  64'(0));
    chk("abort_hilo",  {hi, lo},   64'(0));
    Reset = 1'b1;
    repeat (40) tick();
    chk("abort_no_done", 64'(done_cnt - d0), 64'(0));
    run_op(1'b0, 32'd9, 32'd9, 32'h0000_0000, 32'd81);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
